// File: rtl/st_channel_adapter_pipe_pkg.sv
// Shared framing encoding, beat record macro and channel mapping helper
// for the Avalon-ST channel adapter.
`ifndef ST_ADAPTER_PKG_SV
`define ST_ADAPTER_PKG_SV

`define ST_BEAT_T(DW, CW) struct packed { \
    logic [(DW)-1:0] data;                \
    logic [(CW)-1:0] channel;             \
    logic            sop;                 \
    logic            eop;                 \
    logic            error;               \
}

package st_adapter_pkg;

    localparam logic ST_IDLE   = 1'b0;
    localparam logic ST_IN_PKT = 1'b1;

    localparam int unsigned RAW_CH_W = 8;

    // Returns {ovf, ch}: ch is raw truncated to out_w bits, ovf flags lost high bits.
    function automatic logic [RAW_CH_W:0] map_channel(input logic [RAW_CH_W-1:0] raw,
                                                      input int unsigned      out_w);
        logic [RAW_CH_W-1:0] mask;
        mask = RAW_CH_W'((16'(1) << out_w) - 16'(1));
        return {|(raw & ~mask), raw & mask};
    endfunction

endpackage

`endif

// File: rtl/st_channel_adapter_pipe_if.sv
// Input and output Avalon-ST streams of the channel adapter.
interface st_channel_adapter_pipe_if #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned IN_CH_W  = 1,
    parameter int unsigned OUT_CH_W = 8
);
    logic                in_ready;
    logic                in_valid;
    logic [DATA_W-1:0]   in_data;
    logic [IN_CH_W-1:0]  in_channel;
    logic                in_startofpacket;
    logic                in_endofpacket;
    logic                out_ready;
    logic                out_valid;
    logic [DATA_W-1:0]   out_data;
    logic [OUT_CH_W-1:0] out_channel;
    logic                out_startofpacket;
    logic                out_endofpacket;
    logic                out_error;

    // Environment side: feeds the source stream and consumes the sink stream.
    modport master (
        output in_valid, in_data, in_channel, in_startofpacket, in_endofpacket, out_ready,
        input  in_ready, out_valid, out_data, out_channel, out_startofpacket,
               out_endofpacket, out_error
    );

    // Adapter side.
    modport slave (
        input  in_valid, in_data, in_channel, in_startofpacket, in_endofpacket, out_ready,
        output in_ready, out_valid, out_data, out_channel, out_startofpacket,
               out_endofpacket, out_error
    );
endinterface

// File: rtl/st_channel_adapter_pipe_skid_buffer.sv
// Two-entry registered valid/ready pipe; in_ready and all outputs come from flops.
module st_skid_buffer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o
);

    logic         main_valid_q, main_valid_d;
    logic         skid_valid_q, skid_valid_d;
    logic         in_ready_q, in_ready_d;
    logic [W-1:0] main_q, main_d;
    logic [W-1:0] skid_q, skid_d;
    logic         in_fire;
    logic         out_fire;

    assign in_fire  = in_valid_i & in_ready_q;
    assign out_fire = main_valid_q & out_ready_i;

    // Skid is only ever occupied behind a stalled main entry, so in_fire cannot coincide with it.
    always_comb begin
        main_valid_d = main_valid_q;
        main_d       = main_q;
        skid_valid_d = skid_valid_q;
        skid_d       = skid_q;
        if (skid_valid_q) begin
            if (out_fire) begin
                main_d       = skid_q;
                skid_valid_d = 1'b0;
            end
        end else if (main_valid_q && !out_ready_i) begin
            if (in_fire) begin
                skid_d       = in_data_i;
                skid_valid_d = 1'b1;
            end
        end else begin
            main_valid_d = in_fire;
            if (in_fire) begin
                main_d = in_data_i;
            end
        end
        in_ready_d = !(main_valid_d && skid_valid_d);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b0;
            main_q       <= '0;
            skid_q       <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
            main_q       <= main_d;
            skid_q       <= skid_d;
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = main_valid_q;
    assign out_data_o  = main_q;

endmodule

// File: rtl/st_channel_adapter_pipe.sv
// Avalon-ST channel adapter: channel mapping, packet framing check and
// saturating error count in front of a two-entry skid pipe.
module st_channel_adapter_pipe
    import st_adapter_pkg::*;
#(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned IN_CH_W  = 1,
    parameter int unsigned OUT_CH_W = 8,
    parameter int unsigned CH_SRC   = 0,
    parameter int unsigned CONST_CH = 0,
    parameter int unsigned CH_LATCH = 1,
    parameter int unsigned ERRCNT_W = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    st_channel_adapter_pipe_if.slave bus,
    input  logic                    err_clear,
    output logic [ERRCNT_W-1:0]     err_count
);

    typedef `ST_BEAT_T(DATA_W, OUT_CH_W) beat_t;
    localparam int unsigned BEAT_W = $bits(beat_t);

    logic                state_q, state_d;
    logic [OUT_CH_W-1:0] ch_lat_q, ch_lat_d;
    logic [ERRCNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [RAW_CH_W-1:0] raw_ch;
    logic [RAW_CH_W:0]   mapped;
    logic [OUT_CH_W-1:0] ch_map;
    logic                ch_ovf;
    logic                frame_viol;
    logic                in_ready;
    logic                in_fire;
    beat_t               beat_in;
    beat_t               beat_out;

    assign in_fire = bus.in_valid & in_ready;

    // Channel source select and range mapping.
    always_comb begin
        raw_ch = (CH_SRC == 0) ? RAW_CH_W'(CONST_CH) : RAW_CH_W'(bus.in_channel[IN_CH_W-1:0]);
        mapped = map_channel(raw_ch, OUT_CH_W);
        ch_ovf = mapped[RAW_CH_W];
        ch_map = OUT_CH_W'(mapped[RAW_CH_W-1:0]);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            ch_lat_q  <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            ch_lat_q  <= ch_lat_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // Framing tracker next state; any SOP restarts the packet and relatches the channel.
    always_comb begin
        state_d  = state_q;
        ch_lat_d = ch_lat_q;
        if (in_fire) begin
            if (bus.in_startofpacket) begin
                state_d  = bus.in_endofpacket ? ST_IDLE : ST_IN_PKT;
                ch_lat_d = ch_map;
            end else if (state_q == ST_IN_PKT && bus.in_endofpacket) begin
                state_d = ST_IDLE;
            end
        end
    end

    // Beat assembly and per-beat error flag.
    always_comb begin
        frame_viol      = (state_q == ST_IDLE) ? !bus.in_startofpacket : bus.in_startofpacket;
        beat_in.data    = bus.in_data;
        beat_in.sop     = bus.in_startofpacket;
        beat_in.eop     = bus.in_endofpacket;
        beat_in.channel = ch_map;
        beat_in.error   = frame_viol | ch_ovf;
        if (CH_LATCH != 0) begin
            beat_in.channel = bus.in_startofpacket ? ch_map : ch_lat_q;
            beat_in.error   = frame_viol | (bus.in_startofpacket & ch_ovf);
        end
    end

    // Saturating error counter; clear wins over a same-cycle increment.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_clear) begin
            err_cnt_d = '0;
        end else if (in_fire && beat_in.error && !(&err_cnt_q)) begin
            err_cnt_d = err_cnt_q + ERRCNT_W'(1);
        end
    end

    st_skid_buffer #(.W(BEAT_W)) u_skid (
        .clk         (clk),
        .reset       (reset),
        .in_valid_i  (bus.in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (beat_in),
        .out_valid_o (bus.out_valid),
        .out_ready_i (bus.out_ready),
        .out_data_o  (beat_out)
    );

    assign bus.in_ready          = in_ready;
    assign bus.out_data          = beat_out.data;
    assign bus.out_channel       = beat_out.channel;
    assign bus.out_startofpacket = beat_out.sop;
    assign bus.out_endofpacket   = beat_out.eop;
    assign bus.out_error         = beat_out.error;
    assign err_count             = err_cnt_q;

endmodule

// File: tb/tb_st_channel_adapter_pipe.sv
// Bench for st_channel_adapter_pipe: a constant-channel instance and a
// channel-mapping instance driven in lockstep, checked against a scoreboard.
module tb_st_channel_adapter_pipe;

    typedef struct packed {
        logic [7:0] data;
        logic [7:0] ch;
        logic       sop;
        logic       eop;
        logic       err;
    } exp_t;

    typedef struct {
        logic       sop;
        logic       eop;
        logic [7:0] data;
        logic [3:0] ch;
        logic [1:0] exp_ch1;
        logic       exp_err0;
        logic       exp_err1;
    } vec_t;

    logic       clk;
    logic       reset;
    logic       in_valid, sop, eop, out_ready, err_clear;
    logic [7:0] din;
    logic [3:0] chin;
    logic [7:0] errc0;
    logic [2:0] errc1;

    int   total = 0;
    int   bad   = 0;
    int   pops[2];
    logic stall_p[2];
    exp_t snap_p[2];
    exp_t q0[$];
    exp_t q1[$];
    vec_t vecs[12];

    st_channel_adapter_pipe_if #(.DATA_W(8), .IN_CH_W(1), .OUT_CH_W(8)) if0 ();
    st_channel_adapter_pipe_if #(.DATA_W(8), .IN_CH_W(4), .OUT_CH_W(2)) if1 ();

    st_channel_adapter_pipe #(
        .DATA_W(8), .IN_CH_W(1), .OUT_CH_W(8), .CH_SRC(0), .CONST_CH(5), .CH_LATCH(1), .ERRCNT_W(8)
    ) u0 (
        .clk(clk), .reset(reset), .bus(if0), .err_clear(err_clear), .err_count(errc0)
    );

    st_channel_adapter_pipe #(
        .DATA_W(8), .IN_CH_W(4), .OUT_CH_W(2), .CH_SRC(1), .CONST_CH(0), .CH_LATCH(1), .ERRCNT_W(3)
    ) u1 (
        .clk(clk), .reset(reset), .bus(if1), .err_clear(err_clear), .err_count(errc1)
    );

    assign if0.in_valid         = in_valid;
    assign if0.in_data          = din;
    assign if0.in_channel       = chin[0];
    assign if0.in_startofpacket = sop;
    assign if0.in_endofpacket   = eop;
    assign if0.out_ready        = out_ready;
    assign if1.in_valid         = in_valid;
    assign if1.in_data          = din;
    assign if1.in_channel       = chin;
    assign if1.in_startofpacket = sop;
    assign if1.in_endofpacket   = eop;
    assign if1.out_ready        = out_ready;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one beat; record expectations once it is certain to transfer on the next edge.
    task automatic send(input logic s, input logic e, input logic [7:0] d, input logic [3:0] c,
                        input logic [7:0] ch0, input logic err0, input logic [7:0] ch1,
                        input logic err1);
        int n;
        n        = 0;
        in_valid = 1'b1;
        sop      = s;
        eop      = e;
        din      = d;
        chin     = c;
        while (!(if0.in_ready && if1.in_ready) && n < 50) begin
            tick();
            n++;
        end
        chk($sformatf("send_wait_%0h", d), 32'(n < 50), 32'd1);
        q0.push_back('{data: d, ch: ch0, sop: s, eop: e, err: err0});
        q1.push_back('{data: d, ch: ch1, sop: s, eop: e, err: err1});
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 100) begin
            tick();
            n++;
        end
        chk("drain", 32'(q0.size() + q1.size()), 32'd0);
    endtask

    task automatic mon(input int idx, input logic v, input logic r, input logic [7:0] d,
                       input logic [7:0] ch, input logic s, input logic e, input logic er);
        exp_t cur;
        exp_t want;
        logic empty;
        cur = '{data: d, ch: ch, sop: s, eop: e, err: er};
        if (stall_p[idx]) begin
            chk($sformatf("stall_valid%0d", idx), 32'(v), 32'd1);
            chk($sformatf("stall_hold%0d", idx), 32'(cur), 32'(snap_p[idx]));
        end
        stall_p[idx] = v & ~r;
        snap_p[idx]  = cur;
        if (v && r) begin
            empty = (idx == 0) ? (q0.size() == 0) : (q1.size() == 0);
            chk($sformatf("extra_beat%0d", idx), 32'(empty), 32'd0);
            if (!empty) begin
                want = (idx == 0) ? q0.pop_front() : q1.pop_front();
                chk($sformatf("beat%0d_%0h", idx, want.data), 32'(cur), 32'(want));
                pops[idx]++;
            end
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            stall_p[0] = 1'b0;
            stall_p[1] = 1'b0;
        end else begin
            mon(0, if0.out_valid, out_ready, if0.out_data, if0.out_channel,
                if0.out_startofpacket, if0.out_endofpacket, if0.out_error);
            mon(1, if1.out_valid, out_ready, if1.out_data, 8'(if1.out_channel),
                if1.out_startofpacket, if1.out_endofpacket, if1.out_error);
        end
    end

    initial begin
        //         sop   eop   data   ch     ch1   err0  err1
        vecs[0]  = '{1'b1, 1'b0, 8'h11, 4'd1, 2'd1, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 8'h22, 4'd0, 2'd1, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 8'h33, 4'd1, 2'd1, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 8'h44, 4'd0, 2'd1, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 8'h50, 4'd3, 2'd1, 1'b1, 1'b1};
        vecs[5]  = '{1'b1, 1'b0, 8'h51, 4'd2, 2'd2, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 8'h52, 4'd0, 2'd0, 1'b1, 1'b1};
        vecs[7]  = '{1'b0, 1'b1, 8'h53, 4'd3, 2'd0, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 8'h60, 4'd6, 2'd2, 1'b0, 1'b1};
        vecs[9]  = '{1'b1, 1'b1, 8'h61, 4'd9, 2'd1, 1'b0, 1'b1};
        vecs[10] = '{1'b1, 1'b1, 8'h62, 4'd3, 2'd3, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 8'h63, 4'd4, 2'd0, 1'b0, 1'b1};

        pops[0]   = 0;
        pops[1]   = 0;
        stall_p[0] = 1'b0;
        stall_p[1] = 1'b0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        sop       = 1'b0;
        eop       = 1'b0;
        din       = 8'h00;
        chin      = 4'h0;
        out_ready = 1'b1;
        err_clear = 1'b0;
        repeat (3) tick();

        chk("rst_out_valid", 32'({if0.out_valid, if1.out_valid}), 32'd0);
        chk("rst_in_ready", 32'({if0.in_ready, if1.in_ready}), 32'd0);
        chk("rst_out_fields", 32'({if0.out_data, if0.out_channel, if0.out_startofpacket,
                                   if0.out_endofpacket, if0.out_error}), 32'd0);
        chk("rst_err_count", 32'({errc0, errc1}), 32'd0);
        reset = 1'b0;
        tick();
        chk("post_rst_in_ready", 32'({if0.in_ready, if1.in_ready}), 32'b11);

        // Streaming table: one cycle latency and back-to-back delivery with out_ready high.
        for (int i = 0; i < 12; i++) begin
            send(vecs[i].sop, vecs[i].eop, vecs[i].data, vecs[i].ch, 8'd5, vecs[i].exp_err0,
                 8'(vecs[i].exp_ch1), vecs[i].exp_err1);
            chk($sformatf("row%0d_latency", i), 32'({if0.out_valid, if0.out_data}),
                32'({1'b1, vecs[i].data}));
            if (i == 7) begin
                chk("frame_err_count0", 32'(errc0), 32'd2);
                chk("frame_err_count1", 32'(errc1), 32'd2);
            end
        end
        chk("table_err_count0", 32'(errc0), 32'd2);
        chk("table_err_count1", 32'(errc1), 32'd5);

        // Counter saturation on the 3-bit instance.
        for (int i = 0; i < 3; i++) begin
            send(1'b1, 1'b1, 8'(8'hA0 + i), 4'd5, 8'd5, 1'b0, 8'd1, 1'b1);
        end
        chk("sat_err_count1", 32'(errc1), 32'd7);
        chk("sat_err_count0", 32'(errc0), 32'd2);

        // Clear coincident with an erroring beat wins.
        err_clear = 1'b1;
        send(1'b1, 1'b1, 8'hB0, 4'd6, 8'd5, 1'b0, 8'd2, 1'b1);
        err_clear = 1'b0;
        chk("clear_err_count", 32'({errc0, errc1}), 32'd0);
        send(1'b1, 1'b1, 8'hB1, 4'd7, 8'd5, 1'b0, 8'd3, 1'b1);
        chk("after_clear_count", 32'({errc0, errc1}), 32'd1);
        drain();

        // Backpressure: A in main, B in skid, C held off until space frees up.
        out_ready = 1'b0;
        send(1'b1, 1'b0, 8'hA1, 4'd1, 8'd5, 1'b0, 8'd1, 1'b0);
        chk("bp_a_shown", 32'({if0.out_valid, if0.out_data, if0.in_ready}), 32'({1'b1, 8'hA1, 1'b1}));
        send(1'b0, 1'b0, 8'hB2, 4'd0, 8'd5, 1'b0, 8'd1, 1'b0);
        chk("bp_full", 32'({if0.in_ready, if1.in_ready, if0.out_data}), 32'({2'b00, 8'hA1}));
        in_valid = 1'b1;
        sop      = 1'b0;
        eop      = 1'b1;
        din      = 8'hC3;
        chin     = 4'd1;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk($sformatf("bp_hold%0d", i), 32'({if0.in_ready, if1.in_ready, if1.out_data}),
                32'({2'b00, 8'hA1}));
        end
        out_ready = 1'b1;
        send(1'b0, 1'b1, 8'hC3, 4'd1, 8'd5, 1'b0, 8'd1, 1'b0);
        drain();

        // Reset in the middle of a packet with two beats buffered.
        out_ready = 1'b0;
        send(1'b1, 1'b0, 8'h70, 4'd2, 8'd5, 1'b0, 8'd2, 1'b0);
        send(1'b0, 1'b0, 8'h71, 4'd3, 8'd5, 1'b0, 8'd2, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", 32'({if0.out_valid, if1.out_valid, if0.in_ready, if1.in_ready}), 32'd0);
        chk("mid_rst_fields", 32'({if1.out_data, if1.out_channel, if1.out_startofpacket,
                                   if1.out_error}), 32'd0);
        chk("mid_rst_err_count", 32'({errc0, errc1}), 32'd0);
        q0.delete();
        q1.delete();
        repeat (2) tick();
        reset     = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("mid_rst_in_ready", 32'({if0.in_ready, if1.in_ready}), 32'b11);
        send(1'b0, 1'b0, 8'h7F, 4'd2, 8'd0, 1'b1, 8'd0, 1'b1);
        send(1'b1, 1'b1, 8'h80, 4'd1, 8'd5, 1'b0, 8'd1, 1'b0);
        drain();
        chk("final_err_count", 32'({errc0, errc1}), 32'({8'd1, 3'd1}));
        chk("pop_count0", 32'(pops[0]), 32'd22);
        chk("pop_count1", 32'(pops[1]), 32'd22);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/st_channel_adapter_pipe.md
Name: st_channel_adapter_pipe

Overview:
- Parametrised Avalon-ST packet channel adapter. It sits between a byte/packet source (e.g. a JTAG/master bridge stream) and a channelised sink.
- Generalises the fixed 8-bit, constant-channel adapter: configurable data and channel widths, a selectable channel source, and per-packet channel latching.
- Adds a registered 2-entry skid pipeline, so in_ready is a register and not a combinational path from out_ready.
- Checks packet framing and channel range, and counts errors.

Parameters:
- DATA_W, 8, data bus width (1..64).
- IN_CH_W, 1, in_channel width (1..8).
- OUT_CH_W, 8, out_channel width (1..8).
- CH_SRC, 0, channel source: 0 = constant CONST_CH, 1 = in_channel.
- CONST_CH, 0, channel value used when CH_SRC=0. Must fit in OUT_CH_W.
- CH_LATCH, 1, 1 = channel sampled on the SOP beat and held for the whole packet; 0 = channel taken per beat.
- ERRCNT_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- in_ready  out  1  sink ready; registered
- in_valid  in  1  source beat valid
- in_data  in  DATA_W  beat payload
- in_channel  in  IN_CH_W  source channel; ignored when CH_SRC=0
- in_startofpacket  in  1  SOP marker
- in_endofpacket  in  1  EOP marker
- out_ready  in  1  downstream ready
- out_valid  out  1  output beat valid
- out_data  out  DATA_W  payload
- out_channel  out  OUT_CH_W  mapped channel
- out_startofpacket  out  1  SOP
- out_endofpacket  out  1  EOP
- out_error  out  1  beat flag: channel out of range or framing violation on this beat
- err_count  out  ERRCNT_W  saturating count of flagged beats
- err_clear  in  1  synchronous clear of err_count

Behaviour:
- Reset values (async): all out_* = 0, in_ready = 0, err_count = 0, in_packet = 0, latched channel = 0, skid buffer empty.
- First cycle after reset release: in_ready = 1.

Transfer rules:
- An input beat transfers when in_valid & in_ready; an output beat transfers when out_valid & out_ready.
- out_valid must not drop, and out_* must not change, while out_valid=1 and out_ready=0.

Pipeline:
- Main register plus one skid register.
- Latency: 1 cycle from input transfer to out_valid when the pipe is empty.
- Sustained throughput: 1 beat/clk with out_ready held at 1.
- in_ready next = ~(skid full next). Full means both registers are occupied.
- A beat arriving while the main register stalls goes into skid. Skid drains into main on the next output transfer.
- Beat ordering is preserved.

Channel mapping:
- raw = CONST_CH when CH_SRC=0; otherwise in_channel, zero-extended to OUT_CH_W.
- When IN_CH_W > OUT_CH_W and raw >= 2**OUT_CH_W: truncate to the low OUT_CH_W bits and set out_error on that beat.
- CH_LATCH=1:
  - On a transferred SOP beat, the mapped channel is latched.
  - Non-SOP beats carry the latched channel.
  - An out-of-range flag is raised only on the SOP beat.

Framing tracker (state IDLE / IN_PKT, updated on input transfer only):
- IDLE + SOP, no EOP -> IN_PKT.
- IDLE + SOP + EOP -> IDLE (single-beat packet, legal).
- IDLE + no SOP -> violation: out_error=1; the beat is forwarded with the last latched channel; state unchanged.
- IN_PKT + SOP -> violation: out_error=1; the beat restarts the packet (channel relatched); the state follows that beat's EOP.
- IN_PKT + EOP, no SOP -> IDLE.

Error counter:
- err_count increments by 1 per transferred input beat that will carry out_error=1.
- Saturates at all-ones.
- err_clear has priority over an increment in the same cycle; the result is 0.

Boundary conditions:
- Simultaneous input and output transfer when full is impossible, because in_ready=0.
- Simultaneous input and output transfer when main is valid and skid is empty: main reloads directly from the input.
- Reset asserted mid-packet: the pipeline and tracker are cleared, and in-flight beats are discarded.

Decomposition:
- Package st_adapter_pkg holds:
  - localparam ST_IDLE/ST_IN_PKT, the two-state framing encoding;
  - a beat record typedef {data, channel, sop, eop, error} parameterised by width through macros;
  - the function map_channel(raw, out_w) returning {ovf, ch}.
- One natural sub-module: st_skid_buffer, a generic 2-entry registered pipe with valid/ready on a packed payload of width W.
- The top level contains only the channel mapping, the framing tracker and the error counter.

Test Plan:
- Reset then stream 4 beats (SOP data 0x11, 0x22, 0x33, EOP 0x44), CH_SRC=0, CONST_CH=5, out_ready=1 -> beats appear 1 cycle later, back-to-back, out_channel=5, SOP/EOP on the first/last beat, out_error=0, err_count=0.
- CH_SRC=1, CH_LATCH=1: SOP beat with in_channel=1, then in_channel toggles 0/1 on the following beats -> all beats of the packet show out_channel=1.
- Backpressure: out_ready=0 for 3 cycles while sending beats A, B, C -> in_ready falls after A and B are captured, out_* stay stable on A, C stalls at the input; out_ready=1 -> A, B, C are delivered in order with no loss or duplication.
- Framing: a beat without SOP in IDLE, then SOP, SOP, EOP -> out_error=1 on the 1st and 3rd beats; err_count=2; state returns to IDLE.
- IN_CH_W=4, OUT_CH_W=2: SOP beat with in_channel=6 -> out_channel=2, out_error=1; err_clear pulsed in the same cycle as a second error -> err_count=0.
- Assert reset mid-packet with 2 beats buffered -> all outputs go to 0 immediately (async); after release, a new SOP packet passes cleanly with no stale beats.
